// File: rtl/solver_ctrl.sv
// solver_ctrl: MMIO CSR decode, solver run sequencing and read responses for the ODE solver AFU
module solver_ctrl #(
  parameter logic [63:0] AFU_ID_L = 64'h0,
  parameter logic [63:0] AFU_ID_H = 64'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] mmio_addr,
  input  logic [8:0]  mmio_tid,
  input  logic        mmio_wr_valid,
  input  logic [63:0] mmio_wr_data,
  input  logic        mmio_rd_valid,
  output logic [8:0]  rsp_tid,
  output logic [63:0] rsp_data,
  output logic        rsp_valid,
  output logic [63:0] cfg_buf_addr,
  output logic [31:0] cfg_count,
  output logic        solver_start,
  output logic        solver_abort,
  input  logic        solver_done
);
  typedef enum logic [1:0] {IDLE, START, RUN, DONE} state_t;
  state_t state, state_n;
  logic [63:0] buf_addr, cycles, rd_data;
  logic [31:0] count, runs;
  logic done_s, err_s, abort_s, abort_n, err_set;
  logic [14:0] qa;
  logic mapped, wr_ctrl, wr_buf, wr_cnt, st, ab, clr, busy, start_entry;
  assign qa = mmio_addr[15:1];
  assign mapped = !mmio_addr[0];
  assign wr_ctrl = mmio_wr_valid && mapped && qa == 15'h10;
  assign wr_buf = mmio_wr_valid && mapped && qa == 15'h12;
  assign wr_cnt = mmio_wr_valid && mapped && qa == 15'h13;
  assign st = wr_ctrl && mmio_wr_data[0];
  assign ab = wr_ctrl && mmio_wr_data[1];
  assign clr = wr_ctrl && mmio_wr_data[2];
  assign busy = state != IDLE;
  assign start_entry = state == IDLE && state_n == START;
  assign solver_start = state == START;
  assign cfg_buf_addr = buf_addr;
  assign cfg_count = count;
  // Abort outranks start and done; start+abort in IDLE is a silent no-op.
  always_comb begin
    state_n = state;
    abort_n = 1'b0;
    err_set = busy && (wr_buf || wr_cnt);
    case (state)
      IDLE: state_n = (st && !ab) ? START : IDLE;
      START: begin
        state_n = ab ? IDLE : RUN;
        abort_n = ab;
        err_set = err_set || (st && !ab);
      end
      RUN: begin
        state_n = ab ? IDLE : solver_done ? DONE : RUN;
        abort_n = ab;
        err_set = err_set || (st && !ab);
      end
      default: begin
        state_n = IDLE;
        err_set = err_set || st;
      end
    endcase
  end
  always_comb begin
    rd_data = 64'h0;
    if (mapped)
      case (qa)
        15'h00: rd_data = 64'h1000_0000_0000_0000;
        15'h01: rd_data = AFU_ID_L;
        15'h02: rd_data = AFU_ID_H;
        15'h11: rd_data = {59'h0, abort_s, err_s, done_s, state};
        15'h12: rd_data = buf_addr;
        15'h13: rd_data = {32'h0, count};
        15'h14: rd_data = cycles;
        15'h15: rd_data = {32'h0, runs};
        default: rd_data = 64'h0;
      endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      buf_addr <= '0;
      count <= '0;
      cycles <= '0;
      runs <= '0;
      done_s <= 1'b0;
      err_s <= 1'b0;
      abort_s <= 1'b0;
      solver_abort <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_tid <= '0;
      rsp_data <= '0;
    end else begin
      state <= state_n;
      solver_abort <= abort_n;
      done_s <= (done_s && !clr && !start_entry) || state == DONE;
      abort_s <= (abort_s && !clr && !start_entry) || abort_n;
      err_s <= (err_s && !clr) || err_set;
      cycles <= start_entry ? 64'h0 : (state == RUN && !(&cycles)) ? cycles + 64'h1 : cycles;
      runs <= runs + {31'h0, state == DONE};
      if (wr_buf && !busy) buf_addr <= mmio_wr_data;
      if (wr_cnt && !busy) count <= mmio_wr_data[31:0];
      rsp_valid <= mmio_rd_valid;
      if (mmio_rd_valid) begin
        rsp_tid <= mmio_tid;
        rsp_data <= rd_data;
      end
    end
  end
endmodule

// File: tb/tb_solver_ctrl.sv
// tb_solver_ctrl: directed checks of CSR access, run sequencing, abort and reset behaviour
module tb_solver_ctrl;
  localparam logic [63:0] ID_L = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] ID_H = 64'hFEDC_BA98_7654_3210;
  localparam logic [63:0] DFH = 64'h1000_0000_0000_0000;
  logic clk = 0, reset = 0;
  logic [15:0] mmio_addr = '0;
  logic [8:0] mmio_tid = '0;
  logic mmio_wr_valid = 0, mmio_rd_valid = 0, solver_done = 0;
  logic [63:0] mmio_wr_data = '0;
  logic [8:0] rsp_tid;
  logic [63:0] rsp_data, cfg_buf_addr;
  logic rsp_valid, solver_start, solver_abort;
  logic [31:0] cfg_count;
  int n_chk = 0, n_fail = 0, n_start = 0, n_abort = 0;

  solver_ctrl #(.AFU_ID_L(ID_L), .AFU_ID_H(ID_H)) dut (
    .clk(clk), .reset(reset), .mmio_addr(mmio_addr), .mmio_tid(mmio_tid),
    .mmio_wr_valid(mmio_wr_valid), .mmio_wr_data(mmio_wr_data), .mmio_rd_valid(mmio_rd_valid),
    .rsp_tid(rsp_tid), .rsp_data(rsp_data), .rsp_valid(rsp_valid),
    .cfg_buf_addr(cfg_buf_addr), .cfg_count(cfg_count),
    .solver_start(solver_start), .solver_abort(solver_abort), .solver_done(solver_done)
  );

  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (solver_start) n_start++;
    if (solver_abort) n_abort++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [63:0] d);
    mmio_addr = {8'h0, a} >> 2;
    mmio_wr_data = d;
    mmio_wr_valid = 1;
    step();
    mmio_wr_valid = 0;
  endtask

  task automatic rdchk(input string tag, input logic [15:0] wa, input logic [63:0] exp);
    mmio_addr = wa;
    mmio_tid = 9'h1A;
    mmio_rd_valid = 1;
    step();
    mmio_rd_valid = 0;
    chk({tag, "_valid"}, {63'h0, rsp_valid}, 64'h1);
    chk(tag, rsp_data, exp);
  endtask

  initial begin
    step();
    chk("reset_rsp_valid", {63'h0, rsp_valid}, 64'h0);
    chk("reset_outputs", {cfg_buf_addr ^ {32'h0, cfg_count}, 62'h0, solver_start, solver_abort}, 64'h0);
    reset = 1;
    step();
    chk("idle_start", {63'h0, solver_start}, 64'h0);
    mmio_rd_valid = 1;
    mmio_addr = 16'h0; mmio_tid = 9'd5; step();
    chk("rd0_valid", {63'h0, rsp_valid}, 64'h1);
    chk("rd0_tid", {55'h0, rsp_tid}, 64'd5);
    chk("rd0_dfh", rsp_data, DFH);
    mmio_addr = 16'h2; mmio_tid = 9'd6; step();
    chk("rd1_valid", {63'h0, rsp_valid}, 64'h1);
    chk("rd1_tid", {55'h0, rsp_tid}, 64'd6);
    chk("rd1_idl", rsp_data, ID_L);
    mmio_addr = 16'h4; mmio_tid = 9'd7; step();
    chk("rd2_tid", {55'h0, rsp_tid}, 64'd7);
    chk("rd2_idh", rsp_data, ID_H);
    mmio_rd_valid = 0; step();
    chk("rsp_drop", {63'h0, rsp_valid}, 64'h0);
    chk("rsp_hold", rsp_data, ID_H);
    chk("rsp_tid_hold", {55'h0, rsp_tid}, 64'd7);

    wr(8'h90, 64'hDEAD_BEEF_0000_1000);
    wr(8'h98, 64'hFFFF_FFFF_0000_0064);
    chk("cfg_buf", cfg_buf_addr, 64'hDEAD_BEEF_0000_1000);
    chk("cfg_count", {32'h0, cfg_count}, 64'd100);
    rdchk("rd_buf", 16'h24, 64'hDEAD_BEEF_0000_1000);
    rdchk("rd_count", 16'h26, 64'd100);
    rdchk("rd_odd_unmapped", 16'h25, 64'h0);
    rdchk("rd_ctrl_zero", 16'h20, 64'h0);
    wr(8'h4C, 64'h5555);
    chk("unmapped_wr", cfg_buf_addr, 64'hDEAD_BEEF_0000_1000);

    wr(8'h80, 64'h1);
    chk("start_pulse", {63'h0, solver_start}, 64'h1);
    step();
    chk("start_one_cycle", {63'h0, solver_start}, 64'h0);
    repeat (10) step();
    solver_done = 1; step(); solver_done = 0;
    step();
    chk("start_count", 64'(n_start), 64'd1);
    rdchk("status_done", 16'h22, 64'h4);
    rdchk("cycles", 16'h28, 64'd11);
    rdchk("runs", 16'h2A, 64'd1);

    wr(8'h80, 64'h1);
    step();
    rdchk("status_run", 16'h22, 64'h2);
    wr(8'h80, 64'h1);
    wr(8'h98, 64'd55);
    rdchk("status_err", 16'h22, 64'hA);
    chk("count_kept", {32'h0, cfg_count}, 64'd100);
    wr(8'h80, 64'h4);
    rdchk("status_clr", 16'h22, 64'h2);
    wr(8'h80, 64'h2);
    chk("abort_pulse", {63'h0, solver_abort}, 64'h1);
    step();
    chk("abort_one_cycle", 64'(n_abort), 64'd1);
    rdchk("status_abort", 16'h22, 64'h10);
    rdchk("runs_kept", 16'h2A, 64'd1);
    rdchk("cycles_abort", 16'h28, 64'd7);
    solver_done = 1; step(); solver_done = 0;
    rdchk("done_ignored", 16'h22, 64'h10);
    chk("start_total", 64'(n_start), 64'd2);

    mmio_addr = 16'h24; mmio_tid = 9'd9;
    mmio_wr_data = 64'h1234; mmio_wr_valid = 1; mmio_rd_valid = 1;
    step();
    mmio_wr_valid = 0; mmio_rd_valid = 0;
    chk("rw_old_val", rsp_data, 64'hDEAD_BEEF_0000_1000);
    chk("rw_new_cfg", cfg_buf_addr, 64'h1234);

    wr(8'h80, 64'h1);
    step(); step();
    reset = 0;
    #1;
    chk("mid_reset_outs", {cfg_buf_addr | {32'h0, cfg_count}}, 64'h0);
    chk("mid_reset_rsp", {rsp_data[62:0], rsp_valid}, 64'h0);
    step();
    chk("no_abort_on_reset", 64'(n_abort), 64'd1);
    reset = 1;
    step();
    rdchk("status_after_rst", 16'h22, 64'h0);
    rdchk("cycles_after_rst", 16'h28, 64'h0);
    wr(8'h80, 64'h3);
    chk("start_abort_idle", {63'h0, solver_start}, 64'h0);
    rdchk("status_sa_idle", 16'h22, 64'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/solver_ctrl.md
# solver_ctrl

MMIO-facing control block for the ODE solver AFU. It decodes CCI-P MMIO writes and reads, arrived at as header address, tid, data and valid strobes. It holds the mandatory AFU header CSRs plus solver configuration, sequences a solver run (start, run, done, abort) and returns MMIO read responses on the c2 channel fields. It sits between the CCI-P wrapper's unpacked MMIO signals and the solver datapath.

## Interface
- AFU_ID_L, 64'h0, low 64 bits of AFU UUID
- AFU_ID_H, 64'h0, high 64 bits of AFU UUID
- clk  input  1  core clock; all logic synchronous to it
- reset  input  1  asynchronous, active-low reset
- mmio_addr  input  16  MMIO address in 4-byte units (byte offset >> 2)
- mmio_tid  input  9  MMIO transaction id
- mmio_wr_valid  input  1  MMIO write strobe, one cycle
- mmio_wr_data  input  64  MMIO write data
- mmio_rd_valid  input  1  MMIO read strobe, one cycle
- rsp_tid  output  9  read response tid
- rsp_data  output  64  read response data
- rsp_valid  output  1  read response strobe
- cfg_buf_addr  output  64  host buffer address for solver
- cfg_count  output  32  number of steps to solve
- solver_start  output  1  one-cycle start pulse
- solver_abort  output  1  one-cycle abort pulse
- solver_done  input  1  one-cycle completion pulse from solver

## Operation
- Register map, byte offsets, 64-bit, quadword aligned; decode uses mmio_addr[15:1], and mmio_addr[0]=1 is unmapped:
  - 0x00 DFH: read-only, value 64'h1000_0000_0000_0000 (AFU type, EOL).
  - 0x08 ID_L and 0x10 ID_H: read-only, return the parameters.
  - 0x18 and 0x20: read-only, return 0.
  - 0x80 CTRL: write-only, reads return 0. Bit0 = start, bit1 = abort, bit2 = clear status.
  - 0x88 STATUS: read-only. Bit[1:0] = state, bit2 = done sticky, bit3 = err_busy sticky, bit4 = aborted sticky.
  - 0x90 BUF_ADDR: read/write.
  - 0x98 COUNT: read/write, low 32 bits used, upper bits read 0.
  - 0xA0 CYCLES: read-only, 64-bit run-cycle counter.
  - 0xA8 RUNS: read-only, 32-bit completed-run counter, zero-extended.
- Unmapped reads return 0. Unmapped writes are ignored.
- State machine, STATUS[1:0] encoding:
  - IDLE=0: CTRL.start moves the FSM to START.
  - START=1: solver_start=1 for exactly this cycle, then RUN.
  - RUN=2: CYCLES increments each cycle and saturates at all-ones. solver_done moves the FSM to DONE.
  - DONE=3: sets done sticky, RUNS += 1 (wraps at 2^32), then IDLE on the next cycle.
- Entering START clears CYCLES to 0, done sticky and aborted sticky.
- Abort: CTRL.abort in START or RUN pulses solver_abort for one cycle, sets aborted sticky and moves to IDLE. RUNS is not incremented. Abort in IDLE or DONE has no effect.
- Start while not IDLE: ignored, sets err_busy.
- Start and abort written together: abort wins in START/RUN. In IDLE both are ignored except that err_busy is not set.
- Writes to BUF_ADDR or COUNT while state is not IDLE: ignored, set err_busy.
- CTRL.clear resets the done, err_busy and aborted stickies. Clear is applied before any sticky set in the same write.
- solver_done outside RUN is ignored.
- cfg_buf_addr and cfg_count are driven directly from their registers.

## Timing
- Reset (reset=0, asynchronous): state IDLE. All registers and counters 0. rsp_valid, rsp_tid, rsp_data, solver_start, solver_abort all 0. cfg_buf_addr=0, cfg_count=0.
- Read latency is exactly 1 cycle: mmio_rd_valid at cycle N gives rsp_valid=1 at N+1, with rsp_tid = the tid sampled at N.
- Back-to-back reads every cycle are supported with no bubbles.
- rsp_data holds its last value when rsp_valid=0. rsp_tid is registered the same way.
- Read and write in the same cycle (same or different address): the read returns the pre-write value.
- Register effects of a write at cycle N are visible from N+1.
- CTRL.start at N: solver_start=1 at N+1 (START state), RUN from N+2.
- CYCLES counts RUN cycles, including the cycle in which solver_done is sampled.
- solver_done at cycle M: DONE at M+1, IDLE at M+2. STATUS reads done=1 from M+2.
- Reset asserted mid-run: immediate return to IDLE, no solver_abort pulse, pending response dropped.

## Test plan
- Reset then read 0x00, 0x08, 0x10 with tids 5, 6, 7 on consecutive cycles -> three consecutive responses, tids 5/6/7, data 64'h1000_0000_0000_0000, AFU_ID_L, AFU_ID_H.
- Write BUF_ADDR=64'hDEAD_BEEF_0000_1000 and COUNT=100, then read both -> same values, cfg outputs match; upper 32 bits of COUNT read 0.
- Start, hold solver_done low 10 cycles in RUN, then pulse it -> one solver_start pulse, CYCLES=11, STATUS = IDLE with done=1, RUNS=1.
- Start during RUN, and a COUNT write during RUN -> both ignored, err_busy=1, COUNT unchanged. CTRL.clear -> err_busy=0.
- Abort during RUN -> one solver_abort pulse, state IDLE, aborted=1, RUNS unchanged. A later solver_done -> ignored.
- Read CYCLES in the same cycle as a start write; also assert reset mid-RUN -> read returns the old count; after reset all outputs are 0 and state is IDLE.
